// File: rtl/mem_fetch_decode_if.sv
// mem_fetch_decode_if
//  Bundles the external async memory bus and the decoded-instruction
//  valid/ready handshake used by mem_fetch_decode.
//  Signals:
//   MEM_ADDR   ADDR_W  memory address (driven by the fetch master)
//   MEM_DATA   DATA_W  memory read data (driven by the memory side)
//   MEM_OE     1       output enable, active-high
//   MEM_WE     1       write enable (the fetch master holds it low)
//   inst_valid 1       decoded instruction available
//   inst_ready 1       consumer accepts at an edge where valid&ready
//   inst_op    5       opcode field
//   inst_a     3       operand a field
//   inst_b     3       operand b field
//   inst_c     3       operand c field
//   inst_pc    ADDR_W  address the instruction was fetched from
//  Modports:
//   master  the fetch/decode block
//   slave   the memory plus execute-stage side
interface mem_fetch_decode_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_DATA;
  logic              MEM_OE;
  logic              MEM_WE;
  logic              inst_valid;
  logic              inst_ready;
  logic [4:0]        inst_op;
  logic [2:0]        inst_a;
  logic [2:0]        inst_b;
  logic [2:0]        inst_c;
  logic [ADDR_W-1:0] inst_pc;

  modport master (
    output MEM_ADDR, MEM_OE, MEM_WE,
    input  MEM_DATA,
    output inst_valid, inst_op, inst_a, inst_b, inst_c, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  MEM_ADDR, MEM_OE, MEM_WE,
    output MEM_DATA,
    input  inst_valid, inst_op, inst_a, inst_b, inst_c, inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/mem_fetch_decode.sv
// mem_fetch_decode
//  Read-only master for the external 16-bit async memory bus. Fetches the
//  word at the 12-bit PC, holds MEM_OE for WAIT_CYCLES cycles, then splits
//  the sampled word into opcode/a/b/c fields and presents it to the execute
//  stage over a valid/ready handshake. A jump reloads the PC and discards
//  any read in flight.
//  Ports:
//   CLK_n       in   rising-edge system clock
//   RST_n       in   synchronous active-low reset
//   enable      in   1 = keep fetching sequentially
//   jump_valid  in   load PC from jump_addr and flush
//   jump_addr   in   jump target (ADDR_W)
//   bus         master modport of mem_fetch_decode_if (memory bus and
//               instruction handshake)
module mem_fetch_decode #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2,
  parameter int RESET_PC    = 0
) (
  input  logic                CLK_n,
  input  logic                RST_n,
  input  logic                enable,
  input  logic                jump_valid,
  input  logic [ADDR_W-1:0]   jump_addr,
  mem_fetch_decode_if.master  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam int WCNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAIT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] PC_INIT   = ADDR_W'(RESET_PC);

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [WCNT_W-1:0] wcnt;
  logic [DATA_W-1:0] rd_word;

  assign rd_word = bus.MEM_DATA;

  // The two low data bits carry no instruction field.
  logic unused_low_bits;
  assign unused_low_bits = ^rd_word[1:0];

  // Jump outranks every state so an in-flight read is dropped before it can
  // be captured; MEM_ADDR is left alone because OE is already falling.
  always_ff @(posedge CLK_n) begin
    if (!RST_n) begin
      state          <= IDLE;
      pc             <= PC_INIT;
      wcnt           <= '0;
      bus.MEM_ADDR   <= PC_INIT;
      bus.MEM_OE     <= 1'b0;
      bus.MEM_WE     <= 1'b0;
      bus.inst_valid <= 1'b0;
      bus.inst_op    <= '0;
      bus.inst_a     <= '0;
      bus.inst_b     <= '0;
      bus.inst_c     <= '0;
      bus.inst_pc    <= '0;
    end else begin
      bus.MEM_WE <= 1'b0;
      if (jump_valid) begin
        pc             <= jump_addr;
        bus.MEM_OE     <= 1'b0;
        bus.inst_valid <= 1'b0;
        state          <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            bus.MEM_OE <= 1'b0;
            if (enable) begin
              bus.MEM_ADDR <= pc;
              bus.MEM_OE   <= 1'b1;
              wcnt         <= '0;
              state        <= FETCH;
            end
          end
          FETCH: begin
            wcnt <= wcnt + 1'b1;
            if (wcnt == WCNT_LAST) begin
              bus.inst_op    <= rd_word[15:11];
              bus.inst_a     <= rd_word[10:8];
              bus.inst_b     <= rd_word[7:5];
              bus.inst_c     <= rd_word[4:2];
              bus.inst_pc    <= pc;
              pc             <= pc + 1'b1;
              bus.MEM_OE     <= 1'b0;
              bus.inst_valid <= 1'b1;
              state          <= HOLD;
            end
          end
          HOLD: begin
            // Back-to-back: the accepting edge also launches the next read.
            if (bus.inst_ready) begin
              bus.inst_valid <= 1'b0;
              if (enable) begin
                bus.MEM_ADDR <= pc;
                bus.MEM_OE   <= 1'b1;
                wcnt         <= '0;
                state        <= FETCH;
              end else begin
                state <= IDLE;
              end
            end
          end
          default: begin
            bus.MEM_OE     <= 1'b0;
            bus.inst_valid <= 1'b0;
            state          <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_fetch_decode.sv
// tb_mem_fetch_decode
//  Drives mem_fetch_decode against a 4K-word memory array, compares every
//  output each cycle against a behavioural reference, and pins the reference
//  with hand-computed values for reset, decode, hold, wrap, jump and reset
//  abort cases before a long randomized run.
module tb_mem_fetch_decode;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int WAIT   = 2;

  logic              CLK_n = 1'b0;
  logic              RST_n = 1'b0;
  logic              enable = 1'b0;
  logic              jump_valid = 1'b0;
  logic [ADDR_W-1:0] jump_addr = '0;

  logic [DATA_W-1:0] mem [0:4095];

  int vectors = 0;
  int miscompares = 0;

  mem_fetch_decode_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_fetch_decode #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(WAIT), .RESET_PC(0)
  ) dut (
    .CLK_n(CLK_n),
    .RST_n(RST_n),
    .enable(enable),
    .jump_valid(jump_valid),
    .jump_addr(jump_addr),
    .bus(bus)
  );

  always #5 CLK_n = ~CLK_n;

  // Asynchronous memory: data follows the address.
  assign bus.MEM_DATA = mem[bus.MEM_ADDR];

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs for the next rising edge, then return once outputs have settled.
  task automatic applyStimulus(input logic rst_n_v, input logic en_v, input logic rdy_v,
                               input logic jv_v, input logic [ADDR_W-1:0] ja_v);
    RST_n          = rst_n_v;
    enable         = en_v;
    bus.inst_ready = rdy_v;
    jump_valid     = jv_v;
    jump_addr      = ja_v;
    @(negedge CLK_n);
    #1;
  endtask

  task automatic waitValid(input string name, input logic rdy_v);
    int n = 0;
    while (!bus.inst_valid && n < 20) begin
      applyStimulus(1'b1, 1'b1, rdy_v, 1'b0, '0);
      n++;
    end
    checkOutput(name, {15'd0, bus.inst_valid}, 16'd1);
  endtask

  // Reference: a read is "in flight" for WAIT edges after it starts, the
  // word is presented until a consumer takes it, and jumps/reset drop work.
  bit          model_on = 0;
  int          m_pc, m_addr, m_ipc, m_age;
  bit          m_oe, m_valid;
  logic [15:0] m_word;

  task automatic startRead();
    m_addr = m_pc;
    m_oe   = 1;
    m_age  = 0;
  endtask

  always @(posedge CLK_n) begin
    if (!RST_n) begin
      model_on = 1;
      m_pc = 0; m_addr = 0; m_ipc = 0; m_age = 0;
      m_oe = 0; m_valid = 0; m_word = '0;
    end else if (jump_valid) begin
      m_pc    = int'(jump_addr);
      m_oe    = 0;
      m_valid = 0;
    end else if (m_oe) begin
      m_age++;
      if (m_age == WAIT) begin
        m_word  = mem[m_addr];
        m_ipc   = m_pc;
        m_pc    = (m_pc + 1) % 4096;
        m_oe    = 0;
        m_valid = 1;
      end
    end else if (m_valid) begin
      if (bus.inst_ready) begin
        m_valid = 0;
        if (enable) startRead();
      end
    end else if (enable) begin
      startRead();
    end
  end

  always @(negedge CLK_n) begin
    if (model_on) begin
      checkOutput("mem_oe",     {15'd0, bus.MEM_OE},     {15'd0, m_oe});
      checkOutput("mem_we",     {15'd0, bus.MEM_WE},     16'd0);
      checkOutput("inst_valid", {15'd0, bus.inst_valid}, {15'd0, m_valid});
      checkOutput("mem_addr",   {4'd0, bus.MEM_ADDR},    16'(m_addr));
      checkOutput("inst_op",    {11'd0, bus.inst_op},    {11'd0, m_word[15:11]});
      checkOutput("inst_a",     {13'd0, bus.inst_a},     {13'd0, m_word[10:8]});
      checkOutput("inst_b",     {13'd0, bus.inst_b},     {13'd0, m_word[7:5]});
      checkOutput("inst_c",     {13'd0, bus.inst_c},     {13'd0, m_word[4:2]});
      checkOutput("inst_pc",    {4'd0, bus.inst_pc},     16'(m_ipc));
    end
  end

  initial begin
    bus.inst_ready = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1A5C;
    @(negedge CLK_n);
    #1;

    // Reset held with enable high.
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
    checkOutput("rst_oe",    {15'd0, bus.MEM_OE},     16'd0);
    checkOutput("rst_we",    {15'd0, bus.MEM_WE},     16'd0);
    checkOutput("rst_valid", {15'd0, bus.inst_valid}, 16'd0);
    checkOutput("rst_addr",  {4'd0, bus.MEM_ADDR},    16'h000);

    // First fetch of 0x1A5C: OE for two cycles, then op=3 a=2 b=2 c=7.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0);
    checkOutput("oe_rise", {15'd0, bus.MEM_OE}, 16'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0);
    checkOutput("oe_second", {15'd0, bus.MEM_OE}, 16'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0);
    checkOutput("first_valid", {15'd0, bus.inst_valid}, 16'd1);
    checkOutput("lit_op", {11'd0, bus.inst_op}, 16'd3);
    checkOutput("lit_a",  {13'd0, bus.inst_a},  16'd2);
    checkOutput("lit_b",  {13'd0, bus.inst_b},  16'd2);
    checkOutput("lit_c",  {13'd0, bus.inst_c},  16'd7);
    checkOutput("lit_pc", {4'd0, bus.inst_pc},  16'h000);

    // Stall with ready low: fields hold, no new read.
    repeat (10) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0);
    checkOutput("stall_valid", {15'd0, bus.inst_valid}, 16'd1);
    checkOutput("stall_oe",    {15'd0, bus.MEM_OE},     16'd0);
    checkOutput("stall_op",    {11'd0, bus.inst_op},    16'd3);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0);
    checkOutput("accept_oe",   {15'd0, bus.MEM_OE},   16'd1);
    checkOutput("accept_addr", {4'd0, bus.MEM_ADDR},  16'h001);

    // Streaming with ready high.
    repeat (12) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0);

    // Jump to 0xFFF and check the wrap to 0x000.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 12'hFFF);
    waitValid("wrap_valid0", 1'b0);
    checkOutput("wrap_pc0", {4'd0, bus.inst_pc}, 16'h0FFF);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0);
    waitValid("wrap_valid1", 1'b0);
    checkOutput("wrap_pc1", {4'd0, bus.inst_pc}, 16'h0000);

    // Jump during OE: aborted read never shows up.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0);
    checkOutput("pre_jump_oe", {15'd0, bus.MEM_OE}, 16'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 12'h040);
    checkOutput("jump_oe",    {15'd0, bus.MEM_OE},     16'd0);
    checkOutput("jump_valid", {15'd0, bus.inst_valid}, 16'd0);
    waitValid("jump_next_valid", 1'b0);
    checkOutput("jump_pc", {4'd0, bus.inst_pc}, 16'h0040);

    // Reset during OE: instruction lost, fetch restarts at 0.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, '0);
    checkOutput("pre_rst_oe", {15'd0, bus.MEM_OE}, 16'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
    checkOutput("midrst_oe",    {15'd0, bus.MEM_OE},     16'd0);
    checkOutput("midrst_addr",  {4'd0, bus.MEM_ADDR},    16'h000);
    checkOutput("midrst_valid", {15'd0, bus.inst_valid}, 16'd0);
    checkOutput("midrst_op",    {11'd0, bus.inst_op},    16'd0);
    waitValid("post_rst_valid", 1'b0);
    checkOutput("post_rst_pc", {4'd0, bus.inst_pc}, 16'h0000);

    // Randomized traffic, compared every cycle by the reference.
    for (int i = 0; i < 3000; i++) begin
      logic              r_rst_n, r_en, r_rdy, r_jv;
      logic [ADDR_W-1:0] r_ja;
      r_rst_n = ($urandom_range(0, 63) != 0);
      r_en    = ($urandom_range(0, 7) != 0);
      r_rdy   = ($urandom_range(0, 2) != 0);
      r_jv    = ($urandom_range(0, 15) == 0);
      r_ja    = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom);
      if ($urandom_range(0, 9) == 0) mem[$urandom_range(0, 4095)] = 16'($urandom);
      applyStimulus(r_rst_n, r_en, r_rdy, r_jv, r_ja);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
